// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake and datapath signal around the two-requester ALU
// arbiter. The interface has three groups:
//   * request side  : req_valid/req_ready handshake plus per-requester
//                     operands (req_a, req_b), control (req_ctrl) and shift
//                     width select (req_warith)
//   * response side : rsp_valid/rsp_ready handshake plus rsp_id, rsp_result
//                     and rsp_flags {zero, overflow, sign}
//   * ALU side      : operands/control out to the shared combinational ALU
//                     (alu_a, alu_b, alu_ctrl, alu_warith) and its outputs
//                     back in (alu_result, alu_flags)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters, response consumer and the ALU)
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int N = 64
);

  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [7:0]     req_ctrl;
  logic [1:0]     req_warith;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [N-1:0]   rsp_result;
  logic [2:0]     rsp_flags;

  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [3:0]     alu_ctrl;
  logic           alu_warith;
  logic [N-1:0]   alu_result;
  logic [2:0]     alu_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, req_warith,
    input  rsp_ready,
    input  alu_result, alu_flags,
    output req_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    output alu_a, alu_b, alu_ctrl, alu_warith
  );

  modport master (
    output req_valid, req_a, req_b, req_ctrl, req_warith,
    output rsp_ready,
    output alu_result, alu_flags,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  alu_a, alu_b, alu_ctrl, alu_warith
  );

endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. A request is accepted
// in IDLE, its operands are latched into operand registers that drive the ALU
// for one EXEC cycle, and the ALU outputs are captured into a response that
// is held in RESP until the consumer takes it. Under contention the grant
// alternates; a lone requester is granted on every IDLE visit.
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - synchronous, active-high reset
//   bus_io - alu_arbiter_if.slave carrying request, response and ALU signals
// Parameter:
//   N      - datapath width of the shared ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int N = 64
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q;
  logic         last_grant_q;
  logic         cur_id_q;
  logic [N-1:0] op_a_q;
  logic [N-1:0] op_b_q;
  logic [3:0]   op_ctrl_q;
  logic         op_warith_q;
  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic [N-1:0] rsp_result_q;
  logic [2:0]   rsp_flags_q;

  logic         grant_d;
  logic         take_d;
  logic [1:0]   ready_d;

  // Grant selection: prefer the requester that did not win last time, fall
  // back to the other one. The ready is combinational so that a requester
  // dropping valid before the handshake simply never gets accepted, and it is
  // forced low while reset is high.
  always_comb begin
    grant_d = last_grant_q;
    if (bus_io.req_valid[~last_grant_q]) begin
      grant_d = ~last_grant_q;
    end
    take_d  = (state_q == IDLE) && (bus_io.req_valid != 2'b00) && !reset;
    ready_d = 2'b00;
    if (take_d) begin
      ready_d = grant_d ? 2'b10 : 2'b01;
    end
  end

  // Main FSM. Operand registers only change on a request handshake, so the
  // ALU inputs hold their last values while idle. The response registers only
  // change in EXEC, keeping them stable through RESP until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= 4'b0000;
      op_warith_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_d) begin
            op_a_q       <= grant_d ? bus_io.req_a[2*N-1:N] : bus_io.req_a[N-1:0];
            op_b_q       <= grant_d ? bus_io.req_b[2*N-1:N] : bus_io.req_b[N-1:0];
            op_ctrl_q    <= grant_d ? bus_io.req_ctrl[7:4] : bus_io.req_ctrl[3:0];
            op_warith_q  <= bus_io.req_warith[grant_d];
            cur_id_q     <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= bus_io.alu_result;
          rsp_flags_q  <= bus_io.alu_flags;
          rsp_id_q     <= cur_id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus_io.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.req_ready  = ready_d;
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_id     = rsp_id_q;
  assign bus_io.rsp_result = rsp_result_q;
  assign bus_io.rsp_flags  = rsp_flags_q;
  assign bus_io.alu_a      = op_a_q;
  assign bus_io.alu_b      = op_b_q;
  assign bus_io.alu_ctrl   = op_ctrl_q;
  assign bus_io.alu_warith = op_warith_q;

endmodule
